div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Multi-cycle controller and datapath for the RV32M DIV/DIVU/REM/REMU instructions in the EX stage. It accepts an operation from ID/EX, runs a radix-2 restoring shift-subtract loop, applies the RISC-V sign and special-case rules, and returns a single 32-bit result. While it is working it asserts busy, which the hazard unit uses to stall IF/ID/EX.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
CLK  input  1  system clock, rising edge.
RESET  input  1  synchronous, active-high reset.
start  input  1  request to begin an operation; sampled only in IDLE or DONE.
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
rs1  input  XLEN  dividend.
rs2  input  XLEN  divisor.
flush  input  1  pipeline flush; synchronously aborts any operation.
busy  output  1  high in SETUP, ITER and FIXUP.
done  output  1  one-cycle pulse while in DONE.
result  output  XLEN  registered result, valid while done=1; holds its value until the next done.

Behaviour:
- One clock domain (CLK). RESET is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal quotient/remainder registers=0.
- States: IDLE, SETUP, ITER, FIXUP, DONE.
- IDLE, start=1 at edge N:
  - Latch op, rs1 and rs2; go to SETUP.
- SETUP (edge N+1):
  - Signed ops (DIV, REM): take absolute values of the operands; record neg_q = sign(rs1) XOR sign(rs2) and neg_r = sign(rs1).
  - Check special cases; if one applies, load result and go to DONE.
  - Otherwise clear the remainder, load the quotient register with |dividend|, counter=0, go to ITER.
- Special cases (detected in SETUP):
  - rs2=0: DIV/DIVU return all-ones; REM/REMU return rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.
  - For a special case, done is high in the cycle after edge N+1.
- ITER, one step per edge:
  - {rem,quo} shifted left 1; trial = rem − |divisor| at XLEN+1 bits.
  - If trial is non-negative, rem=trial and quo LSB=1; otherwise quo LSB=0.
  - Counter increments; after XLEN steps (edge N+33) go to FIXUP.
- FIXUP (edge N+34):
  - result = neg_q ? −quo : quo for DIV; neg_r ? −rem : rem for REM; raw values for the unsigned ops.
  - Go to DONE.
- DONE:
  - done=1 for exactly one cycle, so a normal operation has done high in the cycle after edge N+34.
  - At the next edge: if start=1 (and flush=0), accept it and go to SETUP (back-to-back operation); otherwise go to IDLE.
- busy timing: high from the cycle after edge N until FIXUP exits, i.e. 34 cycles for a normal operation and 1 cycle for a special case. It is never high in IDLE or DONE.
- start when not in IDLE or DONE: ignored; the operands are not re-latched.
- flush=1 at any edge: next state is IDLE; done is not asserted and result is not updated.
  - flush has priority over start in the same cycle.
- RESET mid-operation: same as flush, and additionally result is cleared to 0.
- Arithmetic:
  - All negations are two's complement mod 2^XLEN.
  - The subtraction uses XLEN+1 bits so the borrow is visible.
  - |0x80000000| is 0x80000000, interpreted as an unsigned value.

Decomposition:
- Shared encodings include file holds:
  - op codes DIV_OP_DIV/DIVU/REM/REMU (2'b00..2'b11);
  - state constants DIVSQ_IDLE/SETUP/ITER/FIXUP/DONE.
- One sub-module, div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: rem_next, quo_next.
- The FSM, counter and sign/special-case logic stay in div_sequencer.

Test Plan:
- DIV 20/−3 (rs2=0xFFFFFFFD), start at edge N -> busy high for 34 cycles, done in cycle after N+34, result=0xFFFFFFFA; REM on the same operands -> 0x00000002.
- REM −20 % 3 -> 0xFFFFFFFE; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU on the same operands -> 0x00000001.
- DIV 7/0 -> done in cycle after N+1, result=0xFFFFFFFF, busy high for 1 cycle; REMU 7 % 0 -> 0x00000007.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0x00000000, both via the special-case path.
- flush asserted at ITER step 10 -> next cycle IDLE, busy=0, done never pulses, result keeps its previous value; a following DIV 100/7 -> 0x0000000E.
- Back-to-back: start held high in the DONE cycle with DIVU 9/4 -> second done 35 cycles later with result 0x00000002; a start pulse during ITER is ignored; RESET mid-ITER -> result=0, busy=0 the next cycle.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared encodings for the RV32M divide sequencer: opcodes, FSM states and op decode helpers.
package div_sequencer_pkg;

  localparam int unsigned DIV_OP_W  = 2;
  localparam int unsigned DIVSQ_W   = 3;

  typedef enum logic [DIV_OP_W-1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [DIVSQ_W-1:0] {
    DIVSQ_IDLE  = 3'd0,
    DIVSQ_SETUP = 3'd1,
    DIVSQ_ITER  = 3'd2,
    DIVSQ_FIXUP = 3'd3,
    DIVSQ_DONE  = 3'd4
  } divsq_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on the {rem,quo} pair.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    trial   = shifted - {1'b0, divisor};
    // A set top bit in the shifted remainder already exceeds any XLEN-bit divisor.
    fits    = shifted[XLEN] | ~trial[XLEN];
    if (fits) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage: restoring shift-subtract loop
// with RISC-V sign and divide-by-zero/overflow handling; busy stalls the pipeline.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  divsq_state_e    state_q, state_d;
  div_op_e         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            is_signed_c, is_rem_c;
  logic            a_neg_c, b_neg_c, div_zero_c, ovf_c, special_c;
  logic [XLEN-1:0] a_abs_c, b_abs_c, special_res_c;
  logic [XLEN-1:0] rem_step_c, quo_step_c, quo_fix_c, rem_fix_c;

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_step_c),
    .quo_next (quo_step_c)
  );

  // Operand decode: magnitudes, sign flags and special-case result from latched operands.
  always_comb begin
    is_signed_c   = op_is_signed(op_q);
    is_rem_c      = op_is_rem(op_q);
    a_neg_c       = is_signed_c & a_q[XLEN-1];
    b_neg_c       = is_signed_c & b_q[XLEN-1];
    a_abs_c       = a_neg_c ? (~a_q + XLEN'(1)) : a_q;
    b_abs_c       = b_neg_c ? (~b_q + XLEN'(1)) : b_q;
    div_zero_c    = (b_q == '0);
    ovf_c         = is_signed_c && (a_q == MIN_NEG) && (b_q == '1);
    special_c     = div_zero_c | ovf_c;
    if (div_zero_c) begin
      special_res_c = is_rem_c ? a_q : '1;
    end else begin
      special_res_c = is_rem_c ? '0 : MIN_NEG;
    end
    quo_fix_c     = negq_q ? (~quo_q + XLEN'(1)) : quo_q;
    rem_fix_c     = negr_q ? (~rem_q + XLEN'(1)) : rem_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= DIVSQ_IDLE;
      op_q     <= DIV_OP_DIV;
      a_q      <= '0;
      b_q      <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIVSQ_IDLE:  if (start) state_d = DIVSQ_SETUP;
      DIVSQ_SETUP: state_d = special_c ? DIVSQ_DONE : DIVSQ_ITER;
      DIVSQ_ITER:  if (cnt_q == CNT_W'(XLEN - 1)) state_d = DIVSQ_FIXUP;
      DIVSQ_FIXUP: state_d = DIVSQ_DONE;
      DIVSQ_DONE:  state_d = start ? DIVSQ_SETUP : DIVSQ_IDLE;
      default:     state_d = DIVSQ_IDLE;
    endcase
    if (flush) state_d = DIVSQ_IDLE;
  end

  // Datapath and registered status outputs.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    case (state_q)
      DIVSQ_IDLE, DIVSQ_DONE: begin
        if (start) begin
          op_d = div_op_e'(op);
          a_d  = rs1;
          b_d  = rs2;
        end
      end
      DIVSQ_SETUP: begin
        negq_d = a_neg_c ^ b_neg_c;
        negr_d = a_neg_c;
        dvs_d  = b_abs_c;
        if (special_c) begin
          result_d = special_res_c;
        end else begin
          rem_d = '0;
          quo_d = a_abs_c;
          cnt_d = '0;
        end
      end
      DIVSQ_ITER: begin
        rem_d = rem_step_c;
        quo_d = quo_step_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
      DIVSQ_FIXUP: result_d = is_rem_c ? rem_fix_c : quo_fix_c;
      default: ;
    endcase
    if (flush) result_d = result_q;
    busy_d = (state_d == DIVSQ_SETUP) || (state_d == DIVSQ_ITER) || (state_d == DIVSQ_FIXUP);
    done_d = (state_d == DIVSQ_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed RV32M cases plus random operands vs. an arithmetic model.
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'd0;

  div_sequencer #(.XLEN(32)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // RISC-V divide semantics from plain signed/unsigned arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return (o == 2'b10 || o == 2'b11) ? a : 32'hFFFF_FFFF;
    if ((o == 2'b00 || o == 2'b10) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (o == 2'b00) ? 32'h8000_0000 : 32'd0;
    case (o)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_done: got done=1 result=0x%08h expected no done at %0t", result, $time);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // mode: 0 normal, 1 start glitch during ITER at cycle k, 2 flush at cycle k, 3 reset at cycle k
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int mode = 0, input int k = 0);
    logic [31:0] e;
    bit          spec_c;
    int          busy_n, lat;
    e      = ref_model(o, a, b);
    spec_c = (b == 32'd0) || ((o == 2'b00 || o == 2'b10) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (mode < 2) exp_q.push_back(e);
    @(negedge CLK);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    busy_n = 0;
    lat    = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge CLK);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (mode == 1 && i == k) begin
        start = 1'b1; rs1 = ~a; rs2 = 32'd3; op = ~o;
      end else begin
        start = 1'b0;
      end
      if (mode >= 2 && i == k) begin
        if (mode == 2) flush = 1'b1;
        else RESET = 1'b1;
        break;
      end
    end
    if (mode >= 2) begin
      @(negedge CLK);
      flush = 1'b0;
      RESET = 1'b0;
      if (mode == 3) last_result = 32'd0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_result", result, last_result);
      repeat (5) @(negedge CLK);
      check("abort_idle_busy", 32'(busy), 32'd0);
    end else begin
      check("latency", 32'(lat), spec_c ? 32'd2 : 32'd35);
      check("busy_cycles", 32'(busy_n), spec_c ? 32'd1 : 32'd34);
      last_result = e;
    end
  endtask

  // Second op is requested with start held high in the first op's DONE cycle.
  task automatic run_b2b(input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [1:0] o2, input logic [31:0] a2, input logic [31:0] b2);
    int lat1, lat2, busy_n;
    exp_q.push_back(ref_model(o1, a1, b1));
    @(negedge CLK);
    op = o1; rs1 = a1; rs2 = b1; start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    lat1 = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        lat1 = i;
        break;
      end
    end
    check("b2b_first_latency", 32'(lat1), 32'd35);
    op = o2; rs1 = a2; rs2 = b2; start = 1'b1;
    exp_q.push_back(ref_model(o2, a2, b2));
    @(posedge CLK);
    #1 start = 1'b0;
    lat2   = 0;
    busy_n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge CLK);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        lat2 = i;
        break;
      end
    end
    check("b2b_second_latency", 32'(lat2), 32'd35);
    check("b2b_busy_cycles", 32'(busy_n), 32'd34);
    last_result = ref_model(o2, a2, b2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          sel;
    RESET = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge CLK);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    RESET = 1'b0;

    run_op(2'b00, 32'd20, 32'hFFFF_FFFD);
    run_op(2'b10, 32'd20, 32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFEC, 32'd3);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b00, 32'd7, 32'd0);
    run_op(2'b11, 32'd7, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 2, 11);
    run_op(2'b00, 32'd100, 32'd7);
    run_b2b(2'b00, 32'd20, 32'hFFFF_FFFD, 2'b01, 32'd9, 32'd4);
    run_op(2'b01, 32'd1000, 32'd7, 1, 15);
    run_op(2'b00, 32'd20, 32'hFFFF_FFFD, 3, 20);

    for (int n = 0; n < 24; n++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       begin ra = 32'h8000_0000; rb = (n % 2 == 0) ? 32'hFFFF_FFFF : $urandom; end
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
    end

    repeat (4) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
